spmv_csr_feeder: RTL and testbench
==================================

Name: spmv_csr_feeder

Overview:
- Upstream stage of the SpMV compute core.
- Holds one CSR matrix (values, column indices, row pointers) plus the dense input vector, all loaded through a simple write port.
- On start, issues the core start pulse, then streams one nonzero per core MUL/ADD/WRITE pass.
- Presents mat_value, in_vector, count and row_ptr in lock-step with the core's reported state.

Parameters:
NNZ_MAX, 64, depth of value and col_idx arrays (must be at most 255).
N_ROWS, 16, matrix rows; row_ptr has N_ROWS+1 entries of 8 bits.
VEC_LEN, 16, input vector length; column index width is clog2(VEC_LEN).

Ports:
i_clk  in  1  clock; all state updates on its rising edge.
i_rst  in  1  asynchronous active-high reset.
i_load_valid  in  1  load write strobe.
i_load_sel  in  2  target: 0=value, 1=col_idx, 2=vector, 3=row_ptr.
i_load_addr  in  8  element address within the target.
i_load_data  in  16  fp16 value/vector word; col_idx and row_ptr use the low bits.
o_load_ready  out  1  high only in IDLE; loads accepted only when high.
i_start  in  1  begin a run; sampled only in IDLE.
i_core_state  in  3  core state: 0 IDLE, 1 MUL, 2 ADD, 3 WRITE, 4 DONE.
o_core_start  out  1  one-cycle start pulse to the core.
o_mat_value  out  16  fp16 nonzero for the current pass.
o_in_vector  out  16  vector[col_idx[count]].
o_count  out  8  zero-based nonzero index of the current pass.
o_row_ptr  out  136  row_ptr[i] packed at bits [8i+7:8i].
o_busy  out  1  high outside IDLE.
o_done  out  1  one-cycle pulse when a run completes.

Behaviour:
- Reset values: all outputs 0, except o_load_ready=1. FSM=IDLE; row_ptr registers cleared. Value/col/vector arrays are not reset.
- Reset mid-run aborts immediately to IDLE. No o_done is pulsed.
- Loads:
  - Written in the cycle i_load_valid && o_load_ready.
  - Addresses beyond an array's depth are dropped (value/col_idx ≥ NNZ_MAX, vector ≥ VEC_LEN, row_ptr > N_ROWS).
  - o_row_ptr reflects a row_ptr write the next cycle.
- nnz is defined as row_ptr[N_ROWS] (bits 135:128).
- Arrays are register files with combinational read. o_mat_value, o_in_vector and o_count are registered.
- FSM states: IDLE, PRIME, ISSUE, RUN, FIN.
  - IDLE, i_start=1, nnz≠0 -> PRIME.
  - IDLE, i_start=1, nnz=0 -> FIN. The core is never started.
  - PRIME: registers element 0 (o_count=0, o_mat_value=value[0], o_in_vector=vector[col_idx[0]]) -> ISSUE.
  - ISSUE: o_core_start=1 for exactly this cycle -> RUN.
  - RUN, each cycle with i_core_state==WRITE and o_count≠nnz: register element o_count+1 for the next MUL cycle.
  - RUN, i_core_state==WRITE and o_count==nnz -> FIN. Outputs are held.
  - RUN, i_core_state==IDLE observed after the core has left IDLE (core reset) -> IDLE without o_done.
  - FIN: o_done=1 for one cycle -> IDLE.
- Element fetch when index k ≥ nnz: o_mat_value=16'h0000 (fp16 +0), so trailing passes accumulate zero. o_count still advances to k and saturates at nnz.
- Latency: o_core_start occurs 2 cycles after i_start. Each nonzero takes 3 core cycles (MUL, ADD, WRITE). The run ends nnz+1 passes after start, plus 1 cycle of FIN.
- Column index wider than clog2(VEC_LEN): only the low bits are used.
- i_start while busy is ignored. i_load_valid while busy is ignored.
- Output stability: o_mat_value, o_in_vector and o_count change only on the edge that ends a WRITE cycle, or in PRIME. They are stable across MUL, ADD and WRITE.

Decomposition:
- Shared package spmv_pkg holds:
  - core-state encodings CORE_IDLE..CORE_DONE (3'd0..3'd4);
  - load-select codes SEL_VALUE, SEL_COL, SEL_VEC, SEL_RPTR;
  - FP16_ZERO=16'h0000.
- One natural sub-module: spmv_csr_store. It contains the three arrays, the row_ptr register bank, load decode, and the combinational element read (k -> value, vector[col_idx]). The FSM and output registers stay in the top.

Test Plan:
- Load row_ptr={0,1,2,…,2 (rest)}, value[0]=0x3C00, value[1]=0x4000, col_idx={1,0}, vector[0]=0x4200, vector[1]=0x3C00; core model runs IDLE->MUL->ADD->WRITE -> o_core_start 2 cycles after i_start; then (count, mat, vec) = (0, 0x3C00, 0x3C00), then (1, 0x4000, 0x4200); after the WRITE with count=2, o_done pulses once.
- All row_ptr=0, i_start -> no o_core_start, o_done 2 cycles after i_start, o_busy high 1 cycle.
- Set nnz=3 and drive a WRITE with o_count==2 -> o_count=3, o_mat_value=0x0000; next WRITE -> FIN.
- Loads while busy (value[0]=0xFFFF) and i_start mid-run -> ignored; o_load_ready=0; array unchanged after run.
- Assert i_rst during ADD of pass 1 -> all outputs 0 asynchronously, o_load_ready=1, no o_done; a new run after release starts from count 0.
- Loads to value addr 64, vector addr 16, row_ptr addr 17 -> dropped; o_row_ptr unchanged; col_idx=0x13 reads vector[3].

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared encodings for the SpMV CSR feeder: core states, load targets and FSM states.
package spmv_pkg;

    localparam logic [2:0] CORE_IDLE  = 3'd0;
    localparam logic [2:0] CORE_MUL   = 3'd1;
    localparam logic [2:0] CORE_ADD   = 3'd2;
    localparam logic [2:0] CORE_WRITE = 3'd3;
    localparam logic [2:0] CORE_DONE  = 3'd4;

    localparam logic [1:0] SEL_VALUE = 2'd0;
    localparam logic [1:0] SEL_COL   = 2'd1;
    localparam logic [1:0] SEL_VEC   = 2'd2;
    localparam logic [1:0] SEL_RPTR  = 2'd3;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_ISSUE,
        ST_RUN,
        ST_FIN
    } feed_state_t;

endpackage

// File: rtl/spmv_csr_store.sv
// CSR storage: value/col_idx/vector register files, row_ptr bank, load decode and
// combinational element read (k -> value[k], vector[col_idx[k]]).
module spmv_csr_store
    import spmv_pkg::*;
#(
    parameter int NNZ_MAX = 64,
    parameter int N_ROWS  = 16,
    parameter int VEC_LEN = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wr_en,
    input  logic [1:0]                i_wr_sel,
    input  logic [7:0]                i_wr_addr,
    input  logic [15:0]               i_wr_data,
    input  logic [7:0]                i_rd_idx,
    output logic [15:0]               o_rd_value,
    output logic [15:0]               o_rd_vector,
    output logic [8*(N_ROWS+1)-1:0]   o_row_ptr,
    output logic [7:0]                o_nnz
);

    localparam int AW = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1;
    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int RW = $clog2(N_ROWS + 1);

    logic [15:0]   value_mem [NNZ_MAX];
    logic [CW-1:0] col_mem   [NNZ_MAX];
    logic [15:0]   vec_mem   [VEC_LEN];
    logic [7:0]    rptr      [N_ROWS+1];

    logic wr_nz_ok, wr_vec_ok, wr_rp_ok, rd_in, rd_live;

    assign wr_nz_ok  = 32'(i_wr_addr) < NNZ_MAX;
    assign wr_vec_ok = 32'(i_wr_addr) < VEC_LEN;
    assign wr_rp_ok  = 32'(i_wr_addr) <= N_ROWS;

    // Payload arrays carry no reset; only row_ptr defines what is live.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            case (i_wr_sel)
                SEL_VALUE: if (wr_nz_ok)  value_mem[i_wr_addr[AW-1:0]] <= i_wr_data;
                SEL_COL:   if (wr_nz_ok)  col_mem[i_wr_addr[AW-1:0]]   <= i_wr_data[CW-1:0];
                SEL_VEC:   if (wr_vec_ok) vec_mem[i_wr_addr[CW-1:0]]   <= i_wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i <= N_ROWS; i++) rptr[i] <= 8'd0;
        end else if (i_wr_en && i_wr_sel == SEL_RPTR && wr_rp_ok) begin
            rptr[i_wr_addr[RW-1:0]] <= i_wr_data[7:0];
        end
    end

    for (genvar i = 0; i <= N_ROWS; i++) begin : g_rp
        assign o_row_ptr[8*i +: 8] = rptr[i];
    end
    assign o_nnz = rptr[N_ROWS];

    // Past nnz the value reads as +0 so trailing passes accumulate nothing.
    assign rd_in       = 32'(i_rd_idx) < NNZ_MAX;
    assign rd_live     = rd_in && (i_rd_idx < o_nnz);
    assign o_rd_value  = rd_live ? value_mem[i_rd_idx[AW-1:0]] : FP16_ZERO;
    assign o_rd_vector = rd_in ? vec_mem[col_mem[i_rd_idx[AW-1:0]]] : FP16_ZERO;

endmodule

// File: rtl/spmv_csr_feeder.sv
// SpMV CSR feeder: starts the compute core and presents one nonzero per
// MUL/ADD/WRITE pass, advancing on the edge that ends each WRITE.
module spmv_csr_feeder
    import spmv_pkg::*;
#(
    parameter int NNZ_MAX = 64,
    parameter int N_ROWS  = 16,
    parameter int VEC_LEN = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_load_valid,
    input  logic [1:0]                i_load_sel,
    input  logic [7:0]                i_load_addr,
    input  logic [15:0]               i_load_data,
    output logic                      o_load_ready,
    input  logic                      i_start,
    input  logic [2:0]                i_core_state,
    output logic                      o_core_start,
    output logic [15:0]               o_mat_value,
    output logic [15:0]               o_in_vector,
    output logic [7:0]                o_count,
    output logic [8*(N_ROWS+1)-1:0]   o_row_ptr,
    output logic                      o_busy,
    output logic                      o_done
);

    feed_state_t state, state_nxt;
    logic [7:0]  nnz, rd_idx;
    logic [15:0] rd_value, rd_vector;
    logic        seen_active, wr_pass, last;

    spmv_csr_store #(
        .NNZ_MAX (NNZ_MAX),
        .N_ROWS  (N_ROWS),
        .VEC_LEN (VEC_LEN)
    ) u_store (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_en     (i_load_valid && o_load_ready),
        .i_wr_sel    (i_load_sel),
        .i_wr_addr   (i_load_addr),
        .i_wr_data   (i_load_data),
        .i_rd_idx    (rd_idx),
        .o_rd_value  (rd_value),
        .o_rd_vector (rd_vector),
        .o_row_ptr   (o_row_ptr),
        .o_nnz       (nnz)
    );

    assign rd_idx  = (state == ST_PRIME) ? 8'd0 : o_count + 8'd1;
    assign wr_pass = (state == ST_RUN) && (i_core_state == CORE_WRITE);
    assign last    = (o_count == nnz);

    always_comb begin
        state_nxt    = state;
        o_load_ready = 1'b0;
        o_core_start = 1'b0;
        o_busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                o_load_ready = 1'b1;
                o_busy       = 1'b0;
                if (i_start) state_nxt = (nnz == 8'd0) ? ST_FIN : ST_PRIME;
            end
            ST_PRIME: state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                o_core_start = 1'b1;
                state_nxt    = ST_RUN;
            end
            ST_RUN: begin
                // Core dropping back to IDLE after it started means it was reset.
                if (i_core_state == CORE_IDLE && seen_active) state_nxt = ST_IDLE;
                else if (wr_pass && last)                     state_nxt = ST_FIN;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_count     <= 8'd0;
            o_mat_value <= FP16_ZERO;
            o_in_vector <= 16'd0;
            seen_active <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_done      <= (state == ST_FIN);
            seen_active <= (state == ST_RUN) && (seen_active || i_core_state != CORE_IDLE);
            if (state == ST_PRIME) begin
                o_count     <= 8'd0;
                o_mat_value <= rd_value;
                o_in_vector <= rd_vector;
            end else if (wr_pass && !last) begin
                o_count     <= rd_idx;
                o_mat_value <= rd_value;
                o_in_vector <= rd_vector;
            end
        end
    end

endmodule

// File: tb/tb_spmv_csr_feeder.sv
// Directed bench for spmv_csr_feeder; the bench plays the compute core cycle by cycle.
module tb_spmv_csr_feeder;
    import spmv_pkg::*;

    logic         i_clk, i_rst, i_load_valid, i_start;
    logic [1:0]   i_load_sel;
    logic [7:0]   i_load_addr;
    logic [15:0]  i_load_data;
    logic [2:0]   i_core_state;
    logic         o_load_ready, o_core_start, o_busy, o_done;
    logic [15:0]  o_mat_value, o_in_vector;
    logic [7:0]   o_count;
    logic [135:0] o_row_ptr;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] rp_exp [17];

    spmv_csr_feeder dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load_valid (i_load_valid),
        .i_load_sel   (i_load_sel),
        .i_load_addr  (i_load_addr),
        .i_load_data  (i_load_data),
        .o_load_ready (o_load_ready),
        .i_start      (i_start),
        .i_core_state (i_core_state),
        .o_core_start (o_core_start),
        .o_mat_value  (o_mat_value),
        .o_in_vector  (o_in_vector),
        .o_count      (o_count),
        .o_row_ptr    (o_row_ptr),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [135:0] rp_flat();
        logic [135:0] r;
        for (int i = 0; i < 17; i++) r[8*i +: 8] = rp_exp[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [7:0] a, input logic [15:0] d);
        i_load_valid = 1'b1;
        i_load_sel   = sel;
        i_load_addr  = a;
        i_load_data  = d;
        tick();
        i_load_valid = 1'b0;
    endtask

    task automatic core(input logic [2:0] s);
        i_core_state = s;
        tick();
    endtask

    task automatic chk_elem(input string tag, input logic [7:0] c, input logic [15:0] m,
                            input logic [15:0] v, input bit with_vec);
        chk({tag, "_count"}, 136'(o_count), 136'(c));
        chk({tag, "_mat"}, 136'(o_mat_value), 136'(m));
        if (with_vec) chk({tag, "_vec"}, 136'(o_in_vector), 136'(v));
    endtask

    // i_start through PRIME and ISSUE; returns in the first RUN cycle.
    task automatic start_run(input string tag);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk({tag, "_start_c1"}, 136'(o_core_start), 136'(1'b0));
        chk({tag, "_busy_c1"}, 136'(o_busy), 136'(1'b1));
        tick();
        chk({tag, "_start_c2"}, 136'(o_core_start), 136'(1'b1));
        chk_elem({tag, "_e0"}, 8'd0, 16'h3C00, 16'h3C00, 1'b1);
        tick();
        chk({tag, "_start_off"}, 136'(o_core_start), 136'(1'b0));
    endtask

    task automatic pass();
        core(CORE_MUL);
        core(CORE_ADD);
        core(CORE_WRITE);
    endtask

    initial begin
        i_rst = 1'b1; i_load_valid = 1'b0; i_load_sel = 2'd0; i_load_addr = 8'd0;
        i_load_data = 16'd0; i_start = 1'b0; i_core_state = CORE_IDLE;
        for (int i = 0; i < 17; i++) rp_exp[i] = 8'd0;
        #12;
        chk("rst_ready", 136'(o_load_ready), 136'(1'b1));
        chk("rst_busy", 136'(o_busy), 136'(1'b0));
        chk("rst_done", 136'(o_done), 136'(1'b0));
        chk("rst_cstart", 136'(o_core_start), 136'(1'b0));
        chk_elem("rst", 8'd0, 16'h0000, 16'h0000, 1'b1);
        chk("rst_rptr", o_row_ptr, rp_flat());
        tick();
        i_rst = 1'b0;
        tick();

        // Empty matrix: straight to FIN, core never started.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("z_busy1", 136'(o_busy), 136'(1'b1));
        chk("z_done1", 136'(o_done), 136'(1'b0));
        chk("z_cstart1", 136'(o_core_start), 136'(1'b0));
        tick();
        chk("z_busy2", 136'(o_busy), 136'(1'b0));
        chk("z_done2", 136'(o_done), 136'(1'b1));
        chk("z_cstart2", 136'(o_core_start), 136'(1'b0));
        tick();
        chk("z_done3", 136'(o_done), 136'(1'b0));

        for (int i = 0; i < 17; i++) begin
            rp_exp[i] = (i == 0) ? 8'd0 : (i == 1) ? 8'd1 : 8'd2;
            load(SEL_RPTR, 8'(i), 16'(rp_exp[i]));
        end
        load(SEL_VALUE, 8'd0, 16'h3C00);
        load(SEL_VALUE, 8'd1, 16'h4000);
        load(SEL_COL, 8'd0, 16'd1);
        load(SEL_COL, 8'd1, 16'd0);
        load(SEL_VEC, 8'd0, 16'h4200);
        load(SEL_VEC, 8'd1, 16'h3C00);
        // Out-of-range addresses must not alias onto live entries.
        load(SEL_VALUE, 8'd64, 16'h1234);
        load(SEL_VEC, 8'd16, 16'h5555);
        load(SEL_RPTR, 8'd17, 16'h0077);
        chk("rptr_img", o_row_ptr, rp_flat());

        // Run 1: nnz=2, with loads and start attempted while busy.
        start_run("r1");
        i_load_valid = 1'b1; i_load_sel = SEL_VALUE; i_load_addr = 8'd0; i_load_data = 16'hFFFF;
        i_start = 1'b1;
        chk("r1_ready_busy", 136'(o_load_ready), 136'(1'b0));
        core(CORE_MUL);
        i_load_valid = 1'b0;
        i_start = 1'b0;
        core(CORE_ADD);
        chk_elem("r1_hold0", 8'd0, 16'h3C00, 16'h3C00, 1'b1);
        core(CORE_WRITE);
        chk_elem("r1_e1", 8'd1, 16'h4000, 16'h4200, 1'b1);
        pass();
        chk_elem("r1_e2", 8'd2, 16'h0000, 16'h0000, 1'b0);
        pass();
        chk("r1_fin_busy", 136'(o_busy), 136'(1'b1));
        chk("r1_fin_done", 136'(o_done), 136'(1'b0));
        chk("r1_fin_count", 136'(o_count), 136'(8'd2));
        core(CORE_DONE);
        chk("r1_done", 136'(o_done), 136'(1'b1));
        chk("r1_idle", 136'(o_busy), 136'(1'b0));
        core(CORE_IDLE);
        chk("r1_done_off", 136'(o_done), 136'(1'b0));

        // Run 2: nnz=3, col_idx[1]=0x13 selects vector[3].
        rp_exp[16] = 8'd3;
        load(SEL_RPTR, 8'd16, 16'd3);
        load(SEL_VALUE, 8'd2, 16'h4400);
        load(SEL_COL, 8'd2, 16'd2);
        load(SEL_VEC, 8'd2, 16'h4500);
        load(SEL_COL, 8'd1, 16'h0013);
        load(SEL_VEC, 8'd3, 16'h4800);
        chk("rptr_img2", o_row_ptr, rp_flat());
        start_run("r2");
        pass();
        chk_elem("r2_e1", 8'd1, 16'h4000, 16'h4800, 1'b1);
        pass();
        chk_elem("r2_e2", 8'd2, 16'h4400, 16'h4500, 1'b1);
        pass();
        chk_elem("r2_e3", 8'd3, 16'h0000, 16'h0000, 1'b0);
        chk("r2_busy_e3", 136'(o_busy), 136'(1'b1));
        pass();
        chk("r2_fin_busy", 136'(o_busy), 136'(1'b1));
        core(CORE_IDLE);
        chk("r2_done", 136'(o_done), 136'(1'b1));

        // Run 3: async reset during ADD of pass 1.
        start_run("r3");
        pass();
        core(CORE_MUL);
        i_core_state = CORE_ADD;
        #2;
        i_rst = 1'b1;
        #1;
        chk_elem("r3_rst", 8'd0, 16'h0000, 16'h0000, 1'b1);
        chk("r3_rst_busy", 136'(o_busy), 136'(1'b0));
        chk("r3_rst_ready", 136'(o_load_ready), 136'(1'b1));
        chk("r3_rst_done", 136'(o_done), 136'(1'b0));
        for (int i = 0; i < 17; i++) rp_exp[i] = 8'd0;
        chk("r3_rst_rptr", o_row_ptr, rp_flat());
        tick();
        chk("r3_rst_done2", 136'(o_done), 136'(1'b0));
        i_rst = 1'b0;
        i_core_state = CORE_IDLE;
        tick();
        chk("r3_done_after", 136'(o_done), 136'(1'b0));

        // Rerun from count 0, then the core falls back to IDLE mid-pass.
        rp_exp[16] = 8'd2;
        load(SEL_RPTR, 8'd16, 16'd2);
        start_run("r4");
        core(CORE_MUL);
        core(CORE_IDLE);
        chk("r4_abort_busy", 136'(o_busy), 136'(1'b0));
        chk("r4_abort_ready", 136'(o_load_ready), 136'(1'b1));
        tick();
        chk("r4_abort_done", 136'(o_done), 136'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
